delay_ramp_sched: RTL and testbench

//  Generates the faster/slower step pulses for the 4-bit delay register (delay_ctrl).
//  Two sources share that single step interface:
//   - debounced board pushbuttons;
//   - a software-programmed ramp engine that walks the delay toward a target value
//     at a programmable rate.

---
 rtl/delay_ramp_sched.sv | 198 +++++++++++++++++++
 tb/tb_delay_ramp_sched.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/delay_ramp_sched.sv
// Step-pulse scheduler for the 4-bit delay register.
// Debounced pushbuttons and a programmable ramp engine share the faster/slower
// pulse interface; buttons always win. Configured through an 8-bit Avalon-MM slave.
module delay_ramp_sched #(
    parameter int unsigned DEBOUNCE_CYCLES = 1000000,
    parameter int unsigned TICK_CYCLES     = 50000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       key_faster_n,
    input  logic       key_slower_n,
    input  logic [3:0] delay_cur,
    output logic       faster,
    output logic       slower,
    input  logic [1:0] address,
    input  logic       read,
    input  logic       write,
    input  logic       chipselect,
    input  logic [7:0] writedata,
    output logic [7:0] readdata
);

    // Tick counter must hold 255 * TICK_CYCLES - 1.
    localparam int unsigned CntW = $clog2(255 * TICK_CYCLES + 1);
    localparam int unsigned DbW  = $clog2(DEBOUNCE_CYCLES + 1);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_WAIT   = 2'd1;
    localparam logic [1:0] ST_STEP   = 2'd2;
    localparam logic [1:0] ST_SETTLE = 2'd3;

    // Register file
    logic [1:0] ctrl_q, ctrl_d;          // [0] ramp_en, [1] btn_en
    logic [3:0] target_q, target_d;
    logic [7:0] step_div_q, step_div_d;

    // Button path; index 0 = faster key, 1 = slower key. Levels are active-low.
    logic [1:0]     sync1_q, sync2_q;
    logic [1:0]     deb_q, deb_d;
    logic [DbW-1:0] db_cnt_q [2];
    logic [DbW-1:0] db_cnt_d [2];
    logic [1:0]     press;
    logic           btn_fast_q, btn_fast_d;
    logic           btn_slow_q, btn_slow_d;
    logic           btn_pulse;

    // Ramp engine
    logic [1:0]      state_q, state_d;
    logic [CntW-1:0] tick_q, tick_d;
    logic [CntW-1:0] reload;
    logic            ramp_fast, ramp_slow;
    logic            ramp_en, btn_en;
    logic            at_target, busy;

    logic unused_read;
    assign unused_read = read;

    assign ramp_en   = ctrl_q[0];
    assign btn_en    = ctrl_q[1];
    assign at_target = (delay_cur == target_q);
    assign busy      = (state_q != ST_IDLE);
    assign btn_pulse = btn_fast_q | btn_slow_q;

    // Register writes; zero in TARGET or STEP_DIV is clamped to 1.
    always_comb begin
        ctrl_d     = ctrl_q;
        target_d   = target_q;
        step_div_d = step_div_q;
        if (chipselect && write) begin
            unique case (address)
                2'd0: ctrl_d = writedata[1:0];
                2'd1: target_d = (writedata[3:0] == 4'd0) ? 4'd1 : writedata[3:0];
                2'd2: step_div_d = (writedata == 8'd0) ? 8'd1 : writedata;
                default: ;
            endcase
        end
    end

    // Combinational read mux.
    always_comb begin
        readdata = 8'h00;
        unique case (address)
            2'd0: readdata = {6'b0, ctrl_q};
            2'd1: readdata = {4'b0, target_q};
            2'd2: readdata = step_div_q;
            2'd3: readdata = {6'b0, at_target, busy};
            default: readdata = 8'h00;
        endcase
    end

    // Debounce: a new synced level is accepted after DEBOUNCE_CYCLES stable cycles.
    always_comb begin
        for (int k = 0; k < 2; k++) begin
            deb_d[k]    = deb_q[k];
            db_cnt_d[k] = db_cnt_q[k];
            if (sync2_q[k] == deb_q[k]) begin
                db_cnt_d[k] = '0;
            end else if (db_cnt_q[k] == DbW'(DEBOUNCE_CYCLES - 1)) begin
                deb_d[k]    = sync2_q[k];
                db_cnt_d[k] = '0;
            end else begin
                db_cnt_d[k] = db_cnt_q[k] + DbW'(1);
            end
        end
        press = deb_q & ~deb_d;
    end

    // Press edges become one-cycle requests; simultaneous presses cancel.
    always_comb begin
        btn_fast_d = btn_en & press[0] & ~press[1];
        btn_slow_d = btn_en & press[1] & ~press[0];
    end

    // Ramp FSM: wait STEP_DIV ticks, take one step toward TARGET, settle, repeat.
    always_comb begin
        state_d   = state_q;
        tick_d    = tick_q;
        ramp_fast = 1'b0;
        ramp_slow = 1'b0;
        reload    = CntW'(step_div_q) * CntW'(TICK_CYCLES) - CntW'(1);
        case (state_q)
            ST_IDLE: begin
                if (ramp_en && !at_target) begin
                    tick_d  = reload;
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (!ramp_en) begin
                    state_d = ST_IDLE;
                end else if (tick_q == '0) begin
                    state_d = ST_STEP;
                end else begin
                    tick_d = tick_q - CntW'(1);
                end
            end
            ST_STEP: begin
                // A button pulse owns the interface this cycle; retry next cycle.
                if (!btn_pulse) begin
                    if (delay_cur > target_q) begin
                        ramp_fast = 1'b1;
                        state_d   = ST_SETTLE;
                    end else if (delay_cur < target_q) begin
                        ramp_slow = 1'b1;
                        state_d   = ST_SETTLE;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            ST_SETTLE: begin
                if (!ramp_en || at_target) begin
                    state_d = ST_IDLE;
                end else begin
                    tick_d  = reload;
                    state_d = ST_WAIT;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Pulses are suppressed while reset is asserted so a stale STEP cannot leak out.
    always_comb begin
        faster = ~reset & (btn_fast_q | ramp_fast);
        slower = ~reset & (btn_slow_q | ramp_slow);
    end

    // State update with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            ctrl_q     <= 2'b10;
            target_q   <= 4'd8;
            step_div_q <= 8'd1;
            sync1_q    <= 2'b11;
            sync2_q    <= 2'b11;
            deb_q      <= 2'b11;
            for (int k = 0; k < 2; k++) db_cnt_q[k] <= '0;
            btn_fast_q <= 1'b0;
            btn_slow_q <= 1'b0;
            state_q    <= ST_IDLE;
            tick_q     <= '0;
        end else begin
            ctrl_q     <= ctrl_d;
            target_q   <= target_d;
            step_div_q <= step_div_d;
            sync1_q    <= {key_slower_n, key_faster_n};
            sync2_q    <= sync1_q;
            deb_q      <= deb_d;
            for (int k = 0; k < 2; k++) db_cnt_q[k] <= db_cnt_d[k];
            btn_fast_q <= btn_fast_d;
            btn_slow_q <= btn_slow_d;
            state_q    <= state_d;
            tick_q     <= tick_d;
        end
    end

endmodule

// File: tb/tb_delay_ramp_sched.sv
// Directed bench for delay_ramp_sched with a behavioural model of the delay register.
module tb_delay_ramp_sched;

    logic       clk = 1'b0;
    logic       reset;
    logic       key_faster_n, key_slower_n;
    logic [3:0] dly;
    logic       faster, slower;
    logic [1:0] address;
    logic       read, write, chipselect;
    logic [7:0] writedata, readdata;

    logic       dly_load;
    logic [3:0] dly_load_val;
    logic       f_l = 1'b0, s_l = 1'b0;
    int         both_cnt = 0;

    int tests = 0, failed = 0;
    int nf, ns, ff, lf, fs, ls;
    logic [7:0] rv;

    always #5 clk = ~clk;

    delay_ramp_sched #(
        .DEBOUNCE_CYCLES(4),
        .TICK_CYCLES    (3)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .key_faster_n(key_faster_n),
        .key_slower_n(key_slower_n),
        .delay_cur   (dly),
        .faster      (faster),
        .slower      (slower),
        .address     (address),
        .read        (read),
        .write       (write),
        .chipselect  (chipselect),
        .writedata   (writedata),
        .readdata    (readdata)
    );

    // Latch pulses mid-cycle; flag any cycle with both outputs high.
    always @(negedge clk) begin
        f_l <= faster;
        s_l <= slower;
        if (faster && slower) both_cnt <= both_cnt + 1;
    end

    // Delay register model: faster decrements, slower increments.
    always @(posedge clk) begin
        if (dly_load)  dly <= dly_load_val;
        else if (f_l)  dly <= dly - 4'd1;
        else if (s_l)  dly <= dly + 4'd1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            failed++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic wr(input logic [1:0] a, input logic [7:0] d);
        address = a; writedata = d; write = 1'b1; chipselect = 1'b1;
        @(negedge clk);
        write = 1'b0; chipselect = 1'b0;
    endtask

    task automatic rd(input logic [1:0] a, output logic [7:0] d);
        address = a; read = 1'b1; chipselect = 1'b1;
        #1 d = readdata;
        @(negedge clk);
        read = 1'b0; chipselect = 1'b0;
    endtask

    task automatic set_dly(input logic [3:0] v);
        dly_load = 1'b1; dly_load_val = v;
        @(negedge clk);
        dly_load = 1'b0;
    endtask

    // Run n cycles driving per-cycle key levels; record pulse counts and cycle indices.
    task automatic scan(input int n, input logic [63:0] pf, input logic [63:0] ps);
        nf = 0; ns = 0; ff = -1; lf = -1; fs = -1; ls = -1;
        for (int i = 0; i < n; i++) begin
            key_faster_n = pf[i];
            key_slower_n = ps[i];
            if (faster) begin nf++; if (ff < 0) ff = i; lf = i; end
            if (slower) begin ns++; if (fs < 0) fs = i; ls = i; end
            @(negedge clk);
        end
    endtask

    function automatic logic [63:0] low_span(input int a, input int b);
        logic [63:0] v = '1;
        for (int i = a; i <= b; i++) v[i] = 1'b0;
        return v;
    endfunction

    localparam logic [63:0] HI = '1;

    initial begin
        reset = 1'b1; key_faster_n = 1'b1; key_slower_n = 1'b1;
        address = 2'd0; read = 1'b0; write = 1'b0; chipselect = 1'b0; writedata = 8'h00;
        dly_load = 1'b1; dly_load_val = 4'd8;
        repeat (3) @(negedge clk);
        check("rst_faster", {31'b0, faster}, 0);
        check("rst_slower", {31'b0, slower}, 0);
        reset = 1'b0; dly_load = 1'b0;
        check("post_rst_pulse", {30'b0, faster, slower}, 0);
        rd(2'd0, rv); check("rst_ctrl", rv, 8'h02);
        rd(2'd1, rv); check("rst_target", rv, 8'h08);
        rd(2'd2, rv); check("rst_stepdiv", rv, 8'h01);
        rd(2'd3, rv); check("rst_status", rv, 8'h02);

        // T1: 8 -> 3 with STEP_DIV=2 (6-cycle wait): first pulse at 7, then every 8.
        wr(2'd1, 8'd3);
        wr(2'd2, 8'd2);
        wr(2'd0, 8'h03);
        scan(60, HI, HI);
        check("t1_nfast", nf, 5);
        check("t1_nslow", ns, 0);
        check("t1_first", ff, 7);
        check("t1_last", lf, 39);
        check("t1_dly", {28'b0, dly}, 3);
        rd(2'd3, rv); check("t1_status", rv, 8'h02);

        // T2: TARGET=0 clamps to 1; 8 -> 1 with STEP_DIV=1.
        wr(2'd0, 8'h02);
        set_dly(4'd8);
        wr(2'd1, 8'd0);
        rd(2'd1, rv); check("t2_target", rv, 8'h01);
        wr(2'd2, 8'd1);
        wr(2'd0, 8'h03);
        scan(50, HI, HI);
        check("t2_nfast", nf, 7);
        check("t2_first", ff, 4);
        check("t2_last", lf, 34);
        check("t2_dly", {28'b0, dly}, 1);

        // T3: glitches then a 10-cycle hold on the slower key.
        wr(2'd0, 8'h02);
        scan(32, HI, low_span(0, 0) & low_span(3, 3) & low_span(7, 16));
        check("t3_nslow", ns, 1);
        check("t3_nfast", nf, 0);
        check("t3_when", fs, 13);
        check("t3_dly", {28'b0, dly}, 2);

        // T4: button pulse lands on the ramp STEP cycle (cycle 4); ramp follows at 5.
        set_dly(4'd1);
        wr(2'd1, 8'd3);
        key_slower_n = 1'b0;
        @(negedge clk);
        wr(2'd0, 8'h03);
        scan(20, HI, 64'd0);
        check("t4_nslow", ns, 2);
        check("t4_first", fs, 4);
        check("t4_second", ls, 5);
        check("t4_nfast", nf, 0);
        check("t4_dly", {28'b0, dly}, 3);
        scan(12, HI, HI);
        check("t4_release", nf + ns, 0);

        // T5: drop ramp_en mid-WAIT, then reset mid-WAIT.
        wr(2'd0, 8'h02);
        wr(2'd1, 8'd5);
        wr(2'd2, 8'd4);
        wr(2'd0, 8'h03);
        scan(3, HI, HI);
        rd(2'd3, rv); check("t5_busy", rv, 8'h01);
        wr(2'd0, 8'h02);
        scan(1, HI, HI);
        rd(2'd3, rv); check("t5_idle", rv, 8'h00);
        scan(20, HI, HI);
        check("t5_nopulse", nf + ns, 0);
        wr(2'd0, 8'h03);
        scan(5, HI, HI);
        reset = 1'b1;
        @(negedge clk);
        check("t5_rst_out", {30'b0, faster, slower}, 0);
        @(negedge clk);
        reset = 1'b0;
        check("t5_post_rst", {30'b0, faster, slower}, 0);
        rd(2'd0, rv); check("t5_ctrl", rv, 8'h02);
        rd(2'd1, rv); check("t5_target", rv, 8'h08);
        rd(2'd2, rv); check("t5_stepdiv", rv, 8'h01);
        rd(2'd3, rv); check("t5_status", rv, 8'h00);
        scan(30, HI, HI);
        check("t5_quiet", nf + ns, 0);

        // T6: simultaneous presses, presses with btn_en=0, then a normal press.
        scan(32, low_span(0, 11), low_span(0, 11));
        check("t6_both", nf + ns, 0);
        wr(2'd0, 8'h00);
        scan(32, low_span(0, 11), HI);
        check("t6_btn_off", nf + ns, 0);
        wr(2'd0, 8'h02);
        scan(32, low_span(0, 11), HI);
        check("t6_press_n", nf, 1);
        check("t6_press_at", ff, 6);
        check("t6_dly", {28'b0, dly}, 2);
        wr(2'd1, 8'd2);
        rd(2'd3, rv); check("t6_status", rv, 8'h02);
        wr(2'd0, 8'hFF);
        rd(2'd0, rv); check("t6_ctrl_mask", rv, 8'h03);
        wr(2'd2, 8'd0);
        rd(2'd2, rv); check("t6_stepdiv0", rv, 8'h01);
        scan(20, HI, HI);
        check("t6_at_target", nf + ns, 0);

        check("never_both", both_cnt, 0);
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
